// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the parametrised UART receiver and its FIFO.
package uart_rx_pkg;

  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  // Data field is sized for the widest legal frame; narrower frames zero-extend.
  typedef struct packed {
    logic                     frame_err;
    logic                     parity_err;
    logic [MAX_DATA_BITS-1:0] data;
  } rx_entry_t;

  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// First-word-fall-through FIFO: head entry is visible on rdata_o whenever empty_o is low.
module uart_rx_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic                       full_o,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      level_d = level_q + LW'(1);
    else if (do_pop && !do_push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with oversampled bit recovery, glitch/break handling and an error-tagged receive FIFO.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            rx_i,
  input  logic [DIV_W-1:0]                baud_div_i,
  output logic [DATA_BITS-1:0]            data_o,
  output logic                            parity_err_o,
  output logic                            frame_err_o,
  output logic                            valid_o,
  input  logic                            ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] level_o,
  output logic                            overrun_o,
  input  logic                            clear_i,
  output logic                            busy_o
);

  localparam int HALF    = OVERSAMPLE / 2;
  localparam int SC_W    = $clog2(OVERSAMPLE);
  localparam int BI_W    = $clog2(DATA_BITS);
  localparam int LVL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int ENTRY_W = $bits(rx_entry_t);

  logic                 meta_q, meta_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
  logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d, reload;
  logic                 tick, centre;
  rx_state_e            state_q, state_d;
  logic [SC_W-1:0]      sc_q, sc_d;
  logic [BI_W-1:0]      bit_idx_q, bit_idx_d;
  logic                 stop_idx_q, stop_idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 parity_err_q, parity_err_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 push;
  rx_entry_t            push_entry, head;
  logic                 fifo_full, fifo_empty;
  logic [ENTRY_W-1:0]   fifo_rdata;
  logic [LVL_W-1:0]     fifo_level;
  logic                 head_unused;

  assign reload = (baud_div_i == '0) ? '0 : baud_div_i - DIV_W'(1);
  assign tick   = (tick_cnt_q == '0);
  assign centre = tick && (sc_q == SC_W'(OVERSAMPLE - 1));

  always_comb begin
    meta_d     = rx_i;
    rxs_d      = meta_q;
    rxs_prev_d = rxs_q;
    tick_cnt_d = tick ? reload : tick_cnt_q - DIV_W'(1);
  end

  always_comb begin
    state_d      = state_q;
    sc_d         = sc_q;
    bit_idx_d    = bit_idx_q;
    stop_idx_d   = stop_idx_q;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    push         = 1'b0;

    if (tick && state_q != IDLE && state_q != BREAK)
      sc_d = centre ? '0 : sc_q + SC_W'(1);

    case (state_q)
      IDLE: begin
        if (rxs_prev_q && !rxs_q) begin
          state_d      = START;
          sc_d         = '0;
          parity_err_d = 1'b0;
          frame_err_d  = 1'b0;
        end
      end
      START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (tick && sc_q == SC_W'(HALF - 1)) begin
          if (rxs_q) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            sc_d      = '0;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (centre) begin
          data_d    = {rxs_q, data_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + BI_W'(1);
          if (bit_idx_q == BI_W'(DATA_BITS - 1)) begin
            stop_idx_d = 1'b0;
            state_d    = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (centre) begin
          parity_err_d = (rxs_q != parity_bit(MAX_DATA_BITS'(data_q), PARITY_ODD != 0));
          state_d      = STOP;
        end
      end
      STOP: begin
        if (centre) begin
          if (!rxs_q) frame_err_d = 1'b1;
          if (stop_idx_q == 1'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = rxs_q ? IDLE : BREAK;
          end else begin
            stop_idx_d = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The final stop sample is folded in directly because it is taken in the push cycle.
  always_comb begin
    push_entry                       = '0;
    push_entry.frame_err             = frame_err_q | ~rxs_q;
    push_entry.parity_err            = parity_err_q;
    push_entry.data[DATA_BITS-1:0]   = data_q;
  end

  always_comb begin
    overrun_d = overrun_q;
    if (clear_i) overrun_d = 1'b0;
    if (push && fifo_full && !ready_i) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q       <= 1'b1;
      rxs_q        <= 1'b1;
      rxs_prev_q   <= 1'b1;
      tick_cnt_q   <= '0;
      state_q      <= IDLE;
      sc_q         <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      meta_q       <= meta_d;
      rxs_q        <= rxs_d;
      rxs_prev_q   <= rxs_prev_d;
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      sc_q         <= sc_d;
      bit_idx_q    <= bit_idx_d;
      stop_idx_q   <= stop_idx_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  uart_rx_sync_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .wdata_i(push_entry),
    .full_o (fifo_full),
    .pop_i  (ready_i),
    .rdata_o(fifo_rdata),
    .empty_o(fifo_empty),
    .level_o(fifo_level)
  );

  assign head        = fifo_rdata;
  assign head_unused = ^head.data;

  assign valid_o      = !fifo_empty;
  assign data_o       = valid_o ? head.data[DATA_BITS-1:0] : '0;
  assign parity_err_o = valid_o & head.parity_err;
  assign frame_err_o  = valid_o & head.frame_err;
  assign level_o      = fifo_level;
  assign overrun_o    = overrun_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: three instances cover 8N1, 8O2 and a 4-deep FIFO.
module tb_uart_rx_fifo;

  localparam int BIT_CLK = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx [3];
  logic [15:0] baud_div = 16'd4;

  logic [7:0] data0, data1, data2;
  logic       pe0, pe1, pe2, fe0, fe1, fe2;
  logic       valid0, valid1, valid2;
  logic       ready0, ready1, ready2;
  logic [3:0] level0, level1;
  logic [2:0] level2;
  logic       ovr0, ovr1, ovr2;
  logic       clear0, clear1, clear2;
  logic       busy0, busy1, busy2;

  logic [9:0] exp0 [$];
  logic [9:0] exp1 [$];
  logic [9:0] exp2 [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_rx_fifo u_dut0 (
    .clk(clk), .rst(rst), .rx_i(rx[0]), .baud_div_i(baud_div),
    .data_o(data0), .parity_err_o(pe0), .frame_err_o(fe0), .valid_o(valid0),
    .ready_i(ready0), .level_o(level0), .overrun_o(ovr0), .clear_i(clear0), .busy_o(busy0)
  );

  uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .rx_i(rx[1]), .baud_div_i(baud_div),
    .data_o(data1), .parity_err_o(pe1), .frame_err_o(fe1), .valid_o(valid1),
    .ready_i(ready1), .level_o(level1), .overrun_o(ovr1), .clear_i(clear1), .busy_o(busy1)
  );

  uart_rx_fifo #(.FIFO_DEPTH(4)) u_dut2 (
    .clk(clk), .rst(rst), .rx_i(rx[2]), .baud_div_i(baud_div),
    .data_o(data2), .parity_err_o(pe2), .frame_err_o(fe2), .valid_o(valid2),
    .ready_i(ready2), .level_o(level2), .overrun_o(ovr2), .clear_i(clear2), .busy_o(busy2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input int idx, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx[idx] = bits[i];
      cyc(BIT_CLK);
    end
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d, input logic s);
    return {6'b0, s, d, 1'b0};
  endfunction

  function automatic logic [15:0] f8o2(input logic [7:0] d, input logic p, input logic s1, input logic s2);
    return {4'b0, s2, s1, p, d, 1'b0};
  endfunction

  function automatic int qsize(input int idx);
    case (idx)
      0:       return exp0.size();
      1:       return exp1.size();
      default: return exp2.size();
    endcase
  endfunction

  task automatic wait_drain(input int idx);
    int n = 0;
    while (qsize(idx) != 0 && n < 2000) begin
      cyc(1);
      n++;
    end
    chk($sformatf("drain dut%0d", idx), qsize(idx), 0);
  endtask

  // Monitors: one per instance, comparing every popped word with the scoreboard.
  always @(negedge clk) begin
    if (!rst && valid0 && ready0) begin
      if (exp0.size() == 0) begin
        total++; bad++;
        $display("FAIL dut0 unexpected word: got %h expected none", {fe0, pe0, data0});
      end else begin
        $display("dut0 word data=%h pe=%b fe=%b", data0, pe0, fe0);
        chk("dut0 word", {fe0, pe0, data0}, exp0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid1 && ready1) begin
      if (exp1.size() == 0) begin
        total++; bad++;
        $display("FAIL dut1 unexpected word: got %h expected none", {fe1, pe1, data1});
      end else begin
        $display("dut1 word data=%h pe=%b fe=%b", data1, pe1, fe1);
        chk("dut1 word", {fe1, pe1, data1}, exp1.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && valid2 && ready2) begin
      if (exp2.size() == 0) begin
        total++; bad++;
        $display("FAIL dut2 unexpected word: got %h expected none", {fe2, pe2, data2});
      end else begin
        $display("dut2 word data=%h pe=%b fe=%b", data2, pe2, fe2);
        chk("dut2 word", {fe2, pe2, data2}, exp2.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 3; i++) rx[i] = 1'b1;
    ready0 = 1'b1; ready1 = 1'b1; ready2 = 1'b0;
    clear0 = 1'b0; clear1 = 1'b0; clear2 = 1'b0;
    rst = 1'b1;
    cyc(3);
    chk("reset outputs dut0", {busy0, valid0, ovr0, level0, data0, pe0, fe0}, 0);
    chk("reset outputs dut2", {busy2, valid2, ovr2, level2, data2}, 0);
    rst = 1'b0;
    cyc(8);

    // 8N1 0xA5, valid rises one cycle after the final stop-centre tick
    exp0.push_back({2'b00, 8'hA5});
    send_bits(0, f8n1(8'hA5, 1'b1), 9);
    rx[0] = 1'b1;
    n = 0;
    while (!valid0 && n < 80) begin
      cyc(1);
      n++;
    end
    $display("t1 valid after %0d cycles into stop bit", n);
    chk("t1 latency window 31..36", (n >= 31 && n <= 36), 1);
    cyc(2 * BIT_CLK);
    wait_drain(0);

    // Stop bit 0 then long break: exactly one frame-error word
    exp0.push_back({2'b10, 8'h5A});
    send_bits(0, f8n1(8'h5A, 1'b0), 10);
    cyc(15 * BIT_CLK);
    chk("t3 busy mid break", busy0, 1);
    cyc(15 * BIT_CLK);
    chk("t3 busy end break", busy0, 1);
    rx[0] = 1'b1;
    cyc(8);
    chk("t3 busy after release", busy0, 0);
    cyc(BIT_CLK);
    exp0.push_back({2'b00, 8'h11});
    send_bits(0, f8n1(8'h11, 1'b1), 10);
    cyc(BIT_CLK);
    wait_drain(0);

    // Start glitch of three ticks
    rx[0] = 1'b0;
    cyc(10);
    chk("t5 busy during glitch", busy0, 1);
    cyc(2);
    rx[0] = 1'b1;
    cyc(60);
    chk("t5 busy after glitch", busy0, 0);
    chk("t5 level after glitch", level0, 0);

    // Odd parity, two stop bits
    exp1.push_back({2'b01, 8'h03});
    send_bits(1, f8o2(8'h03, 1'b0, 1'b1, 1'b1), 12);
    exp1.push_back({2'b00, 8'h03});
    send_bits(1, f8o2(8'h03, 1'b1, 1'b1, 1'b1), 12);
    exp1.push_back({2'b10, 8'h81});
    send_bits(1, f8o2(8'h81, 1'b1, 1'b1, 1'b0), 12);
    rx[1] = 1'b1;
    cyc(BIT_CLK);
    chk("t5 busy dut1 after break", busy1, 0);
    wait_drain(1);

    // Overrun on a 4-deep FIFO
    for (int v = 1; v <= 5; v++) begin
      if (v <= 4) exp2.push_back({2'b00, 8'(v)});
      send_bits(2, f8n1(8'(v), 1'b1), 10);
      if (v == 4) begin
        chk("t4 level full", level2, 4);
        chk("t4 no overrun at full", ovr2, 0);
      end
    end
    chk("t4 level after drop", level2, 4);
    chk("t4 overrun set", ovr2, 1);
    ready2 = 1'b1;
    wait_drain(2);
    chk("t4 level drained", level2, 0);
    chk("t4 overrun sticky", ovr2, 1);
    clear2 = 1'b1;
    cyc(1);
    clear2 = 1'b0;
    chk("t4 overrun cleared", ovr2, 0);

    // Asynchronous reset mid-frame
    send_bits(0, f8n1(8'hC3, 1'b1), 5);
    chk("t6 busy before reset", busy0, 1);
    rst = 1'b1;
    #1;
    chk("t6 outputs in reset", {busy0, valid0, ovr0, level0, data0, pe0, fe0}, 0);
    rx[0] = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(8);
    ready0 = 1'b0;
    exp0.push_back({2'b00, 8'h3C});
    send_bits(0, f8n1(8'h3C, 1'b1), 10);
    n = 0;
    while (!valid0 && n < 100) begin
      cyc(1);
      n++;
    end
    chk("t6 valid after frame", valid0, 1);
    chk("t6 level one", level0, 1);
    ready0 = 1'b1;
    wait_drain(0);
    cyc(BIT_CLK);

    chk("leftover dut0", exp0.size(), 0);
    chk("leftover dut1", exp1.size(), 0);
    chk("leftover dut2", exp2.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised, synthesizable UART receiver with an error-tagged receive FIFO; successor to the fixed 8N1 UART bus model used on the SoC bench.
- Generalises data width, parity mode, stop-bit count, oversampling and FIFO depth, and adds runtime baud divisor, glitch rejection, break handling and overrun reporting.
- Sits on the SoC UART pins: as the bench-side monitor of the DUT's uart_tx, and as the receive path of the peripheral.

Parameters:
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY_EN, 0, 1 = a parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity; ignored when PARITY_EN=0
STOP_BITS, 1, number of stop bits, 1 or 2
OVERSAMPLE, 16, ticks per bit; even number, 8..32
DIV_W, 16, width of the baud divisor
FIFO_DEPTH, 8, number of receive FIFO entries; power of two, at least 2

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
rx_i  in  1  serial input, asynchronous to clk, idles high
baud_div_i  in  DIV_W  clk cycles per oversample tick; 0 is treated as 1
data_o  out  DATA_BITS  head-of-FIFO payload
parity_err_o  out  1  parity-error tag of the head entry
frame_err_o  out  1  framing-error tag of the head entry
valid_o  out  1  FIFO not empty
ready_i  in  1  consumer pop; a pop happens when valid_o && ready_i
level_o  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy
overrun_o  out  1  sticky: a frame was dropped because the FIFO was full
clear_i  in  1  synchronous clear of overrun_o
busy_o  out  1  receiver FSM is not in IDLE

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM in IDLE, both synchronizer flops 1, tick counter 0.
- rx_i passes through a 2-flop synchronizer. All sampling uses the synchronized value rxs.
- Tick generator:
  - A down-counter reloads with max(baud_div_i,1)-1 and emits a one-cycle tick when it reaches 0.
  - A change of baud_div_i takes effect at the next reload.
- Every state except IDLE and BREAK keeps a sample counter sc (0..OVERSAMPLE-1) that advances on ticks.
- IDLE: a falling edge of rxs (previous 1, current 0) -> START with sc=0. busy_o=1 in every state except IDLE.
- START:
  - When sc reaches OVERSAMPLE/2-1 on a tick, rxs is sampled.
  - rxs=1 is a glitch -> IDLE, and nothing is pushed.
  - rxs=0 -> DATA with sc=0 and bit index 0.
- DATA: sample at sc=OVERSAMPLE-1 (bit centre), LSB first. After DATA_BITS samples -> PARITY if PARITY_EN, otherwise STOP.
- PARITY: sample at the bit centre.
  - Expected bit = XOR of the data bits, inverted when PARITY_ODD.
  - A mismatch sets the word's parity_err.
- STOP:
  - Each of the STOP_BITS stop bits is sampled at its centre. Any stop sample of 0 sets frame_err.
  - The word is pushed on the final stop-sample tick.
  - Next state: IDLE if that final sample was 1, otherwise BREAK.
- BREAK: wait for rxs=1, then -> IDLE. Only one word (frame_err=1, data as sampled) is pushed per break.
- Push latency: valid_o, data_o, level_o and the tags reflect the word one cycle after the push cycle.
- FIFO:
  - First-word-fall-through; the head entry is visible on the outputs whenever valid_o=1.
  - Each entry is {frame_err, parity_err, data}.
  - Pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle:
  - Not full: both happen and level_o is unchanged.
  - Full: the pop frees a slot, so the push is accepted and overrun_o is not set.
  - Empty: only the push happens (no pass-through in the same cycle).
- Push while full with no pop: the word is dropped and overrun_o is set to 1. It stays 1 until clear_i. If clear_i and a new overrun occur in the same cycle, set wins.
- ready_i while empty: ignored.
- Asynchronous rst during a frame: all state returns to reset values immediately. A partial frame is never pushed.

Decomposition:
- Package uart_rx_pkg holds:
  - the FSM enum (IDLE, START, DATA, PARITY, STOP, BREAK)
  - the parametrised entry struct {frame_err, parity_err, data}
  - a parity helper function
- Sub-module uart_rx_sync_fifo: generic FWFT FIFO with WIDTH and DEPTH parameters, level output, push_i/full_o/pop_i/empty_o.
- The top level contains the synchronizer, tick generator, FSM and overrun logic.

Test Plan:
1. Defaults, baud_div_i=4 (64 clk/bit), ready_i=1, send 8N1 0xA5 -> one word data_o=0xA5, both tags 0, valid_o rises 1 cycle after the last stop-centre tick.
2. PARITY_EN=1, PARITY_ODD=1, send 0x03 with parity bit 0 -> parity_err_o=1; resend with parity bit 1 -> parity_err_o=0.
3. Send 0x5A with stop bit 0, then hold rx low for 30 bit times, then release -> exactly one word (0x5A, frame_err_o=1); busy_o stays 1 until rx returns high; next frame 0x11 is received clean.
4. FIFO_DEPTH=4, ready_i=0, send 0x01..0x05 -> level_o=4, overrun_o=1; pops return 0x01..0x04; clear_i for one cycle -> overrun_o=0.
5. rx low for 3 ticks (fewer than OVERSAMPLE/2) then high -> no push, busy_o returns to 0; STOP_BITS=2 with the second stop bit 0 -> frame_err_o=1.
6. Assert rst in the middle of the data bits of 0xC3 -> all outputs 0 immediately; after release, frame 0x3C is received with level_o=1.
